window_bufferizer: RTL and testbench

- Parametrised successor to the single-window audio bufferizer; sits between the sample source/YIN pitch detector and the PSOLA core.
- Captures input samples into a ping-pong window memory and, when a tau arrives, bursts the last completed window to the core at a fixed pacing with addresses.
- Collects processed samples in an output FIFO and plays them out at a fixed sample period, flagging underrun and overflow.

---
 rtl/window_bufferizer.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_window_bufferizer.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_bufferizer.sv
// window_bufferizer: ping-pong window capture, paced burst readout to the PSOLA core and a
// fixed-rate output FIFO. Define WINDOW_BUFFERIZER_HOLD_EN to repeat the last sample on underrun.
module window_bufferizer #(
   parameter int SAMPLE_W     = 16,
   parameter int OUT_W        = 32,
   parameter int TAU_W        = 11,
   parameter int WINDOW_SIZE  = 2048,
   parameter int BURST_PERIOD = 5,
   parameter int OUT_DEPTH    = 4096,
   parameter int PLAY_PERIOD  = 2304
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic [SAMPLE_W-1:0]            sample_in,
   input  logic                           sample_valid_in,
   input  logic [TAU_W-1:0]               tau_in,
   input  logic                           tau_valid_in,
   output logic [TAU_W-1:0]               tau_out,
   output logic                           tau_valid_out,
   output logic [SAMPLE_W-1:0]            burst_sample_out,
   output logic [$clog2(WINDOW_SIZE)-1:0] burst_addr_out,
   output logic                           burst_valid_out,
   output logic                           burst_last_out,
   input  logic [OUT_W-1:0]               proc_sample_in,
   input  logic                           proc_valid_in,
   input  logic                           proc_done_in,
   output logic [OUT_W-1:0]               audio_out,
   output logic                           audio_valid_out,
   output logic                           underrun_out,
   output logic                           overflow_out
);

   localparam int AW = $clog2(WINDOW_SIZE);
   localparam int HW = (BURST_PERIOD > 1) ? $clog2(BURST_PERIOD) : 1;
   localparam int FW = $clog2(OUT_DEPTH);
   localparam int PW = $clog2(PLAY_PERIOD);

   localparam logic [AW-1:0] LAST_ADDR = AW'(WINDOW_SIZE - 1);
   localparam logic [HW-1:0] LAST_HOLD = HW'(BURST_PERIOD - 1);
   localparam logic [PW-1:0] LAST_TICK = PW'(PLAY_PERIOD - 1);
   localparam logic [FW:0]   FULL_CNT  = (FW + 1)'(OUT_DEPTH);

   typedef enum logic [1:0] {B_IDLE, B_BURST, B_WAIT_DONE} burst_state_e;
   typedef enum logic       {P_LOADING, P_PLAYING}         play_state_e;

   // Storage
   logic [SAMPLE_W-1:0] win_mem  [2*WINDOW_SIZE];
   logic [OUT_W-1:0]    fifo_mem [OUT_DEPTH];
   logic [SAMPLE_W-1:0] rd_data_q;

   // Capture and tau queueing
   logic [AW-1:0]       wp_q, wp_d;
   logic                wb_q, wb_d;
   logic                rd_bank_q, rd_bank_d;
   logic                win_avail_q, win_avail_d;
   logic [TAU_W-1:0]    tau_pend_q, tau_pend_d;
   logic                pend_q, pend_d;

   // Burst engine
   burst_state_e        bstate_q, bstate_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [HW-1:0]       hold_q, hold_d;
   logic                lock_bank_q, lock_bank_d;
   logic                rd_valid_q, rd_valid_d;
   logic [AW-1:0]       rd_addr_q, rd_addr_d;
   logic [TAU_W-1:0]    tau_out_q, tau_out_d;
   logic                tau_valid_q, tau_valid_d;
   logic [SAMPLE_W-1:0] burst_sample_q, burst_sample_d;
   logic [AW-1:0]       burst_addr_q, burst_addr_d;
   logic                burst_valid_q, burst_valid_d;
   logic                burst_last_q, burst_last_d;

   // Output FIFO and playback
   play_state_e         pstate_q, pstate_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [FW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [FW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [FW:0]         count_q, count_d;
   logic [OUT_W-1:0]    audio_q, audio_d;
   logic                audio_valid_q, audio_valid_d;
   logic                underrun_q, underrun_d;
   logic                overflow_q, overflow_d;

   logic wrap, burst_start, rd_en, win_ovf;
   logic play_tick, pop, push_ok, fifo_ovf;

   // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      wp_d        = wp_q;
      wb_d        = wb_q;
      rd_bank_d   = rd_bank_q;
      win_avail_d = win_avail_q;
      tau_pend_d  = tau_pend_q;
      pend_d      = pend_q;
      win_ovf     = 1'b0;
      wrap        = sample_valid_in && (wp_q == LAST_ADDR);

      if (sample_valid_in) wp_d = wp_q + 1'b1;
      if (burst_start) begin
         pend_d      = 1'b0;
         win_avail_d = 1'b0;
      end
      // A fresh tau or window in the burst-start cycle is queued for the next burst.
      if (tau_valid_in) begin
         tau_pend_d = tau_in;
         pend_d     = 1'b1;
      end
      if (wrap) begin
         rd_bank_d   = wb_q;
         wb_d        = ~wb_q;
         win_avail_d = 1'b1;
         win_ovf     = (win_avail_q && !burst_start)
                     || ((bstate_q == B_BURST) && (lock_bank_q == ~wb_q))
                     || (burst_start && (rd_bank_q == ~wb_q));
      end
   end

   always_comb begin
      bstate_d    = bstate_q;
      addr_d      = addr_q;
      hold_d      = hold_q;
      lock_bank_d = lock_bank_q;
      tau_out_d   = tau_out_q;
      tau_valid_d = 1'b0;
      burst_start = 1'b0;
      rd_en       = 1'b0;

      case (bstate_q)
         B_IDLE: begin
            if (pend_q && win_avail_q) begin
               burst_start = 1'b1;
               bstate_d    = B_BURST;
               addr_d      = '0;
               hold_d      = '0;
               lock_bank_d = rd_bank_q;
               tau_out_d   = tau_pend_q;
               tau_valid_d = 1'b1;
            end
         end
         B_BURST: begin
            if (hold_q == LAST_HOLD) begin
               rd_en  = 1'b1;
               hold_d = '0;
               addr_d = addr_q + 1'b1;
               if (addr_q == LAST_ADDR) bstate_d = B_WAIT_DONE;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         B_WAIT_DONE: begin
            if (proc_done_in) bstate_d = B_IDLE;
         end
         default: bstate_d = B_IDLE;
      endcase

      // Memory data lands one clock after the read; the output stage adds one more.
      rd_valid_d     = rd_en;
      rd_addr_d      = rd_en ? addr_q : rd_addr_q;
      burst_valid_d  = rd_valid_q;
      burst_last_d   = rd_valid_q && (rd_addr_q == LAST_ADDR);
      burst_sample_d = rd_valid_q ? rd_data_q : burst_sample_q;
      burst_addr_d   = rd_valid_q ? rd_addr_q : burst_addr_q;
   end

   always_comb begin
      pstate_d      = pstate_q;
      pcnt_d        = pcnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      audio_d       = audio_q;
      audio_valid_d = 1'b0;
      underrun_d    = underrun_q;

      play_tick = (pstate_q == P_PLAYING) && (pcnt_q == LAST_TICK);
      pop       = play_tick && (count_q != '0);
      push_ok   = proc_valid_in && ((count_q != FULL_CNT) || pop);
      fifo_ovf  = proc_valid_in && !push_ok;

      if (pstate_q == P_LOADING) begin
         if (proc_done_in) begin
            pstate_d = P_PLAYING;
            pcnt_d   = '0;
         end
      end else begin
         pcnt_d = play_tick ? '0 : pcnt_q + 1'b1;
      end

      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (play_tick) begin
         audio_valid_d = 1'b1;
         if (pop) begin
            audio_d = fifo_mem[rd_ptr_q];
         end else begin
            underrun_d = 1'b1;
`ifdef WINDOW_BUFFERIZER_HOLD_EN
            // audio_q only ever holds the last successfully played sample (or reset 0).
            audio_d = audio_q;
`else
            audio_d = '0;
`endif
         end
      end

      overflow_d = overflow_q || win_ovf || fifo_ovf;
   end

   // NOTE: the sample and FIFO arrays have no reset; pointers and valid flags already make
   // stale contents unobservable, and a reset would prevent RAM inference.
   always_ff @(posedge clk_in) begin
      if (sample_valid_in) win_mem[{wb_q, wp_q}] <= sample_in;
      if (rd_en)           rd_data_q <= win_mem[{lock_bank_q, addr_q}];
      if (push_ok)         fifo_mem[wr_ptr_q] <= proc_sample_in;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wp_q           <= '0;
         wb_q           <= 1'b0;
         rd_bank_q      <= 1'b0;
         win_avail_q    <= 1'b0;
         tau_pend_q     <= '0;
         pend_q         <= 1'b0;
         bstate_q       <= B_IDLE;
         addr_q         <= '0;
         hold_q         <= '0;
         lock_bank_q    <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_addr_q      <= '0;
         tau_out_q      <= '0;
         tau_valid_q    <= 1'b0;
         burst_sample_q <= '0;
         burst_addr_q   <= '0;
         burst_valid_q  <= 1'b0;
         burst_last_q   <= 1'b0;
         pstate_q       <= P_LOADING;
         pcnt_q         <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         audio_q        <= '0;
         audio_valid_q  <= 1'b0;
         underrun_q     <= 1'b0;
         overflow_q     <= 1'b0;
      end else begin
         wp_q           <= wp_d;
         wb_q           <= wb_d;
         rd_bank_q      <= rd_bank_d;
         win_avail_q    <= win_avail_d;
         tau_pend_q     <= tau_pend_d;
         pend_q         <= pend_d;
         bstate_q       <= bstate_d;
         addr_q         <= addr_d;
         hold_q         <= hold_d;
         lock_bank_q    <= lock_bank_d;
         rd_valid_q     <= rd_valid_d;
         rd_addr_q      <= rd_addr_d;
         tau_out_q      <= tau_out_d;
         tau_valid_q    <= tau_valid_d;
         burst_sample_q <= burst_sample_d;
         burst_addr_q   <= burst_addr_d;
         burst_valid_q  <= burst_valid_d;
         burst_last_q   <= burst_last_d;
         pstate_q       <= pstate_d;
         pcnt_q         <= pcnt_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         audio_q        <= audio_d;
         audio_valid_q  <= audio_valid_d;
         underrun_q     <= underrun_d;
         overflow_q     <= overflow_d;
      end
   end

   assign tau_out          = tau_out_q;
   assign tau_valid_out    = tau_valid_q;
   assign burst_sample_out = burst_sample_q;
   assign burst_addr_out   = burst_addr_q;
   assign burst_valid_out  = burst_valid_q;
   assign burst_last_out   = burst_last_q;
   assign audio_out        = audio_q;
   assign audio_valid_out  = audio_valid_q;
   assign underrun_out     = underrun_q;
   assign overflow_out     = overflow_q;

endmodule

// File: tb/tb_window_bufferizer.sv
// Self-checking bench for window_bufferizer: random stimulus against a queue-based window/FIFO
// model; honours WINDOW_BUFFERIZER_HOLD_EN for the underrun value.
module tb_window_bufferizer;

   localparam int SW = 16;
   localparam int OW = 32;
   localparam int TW = 11;
   localparam int WS = 8;
   localparam int BP = 2;
   localparam int OD = 16;
   localparam int PP = 4;
   localparam int AW = $clog2(WS);

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic [SW-1:0] sample_in = '0;
   logic          sample_valid_in = 1'b0;
   logic [TW-1:0] tau_in = '0;
   logic          tau_valid_in = 1'b0;
   logic [TW-1:0] tau_out;
   logic          tau_valid_out;
   logic [SW-1:0] burst_sample_out;
   logic [AW-1:0] burst_addr_out;
   logic          burst_valid_out;
   logic          burst_last_out;
   logic [OW-1:0] proc_sample_in = '0;
   logic          proc_valid_in = 1'b0;
   logic          proc_done_in = 1'b0;
   logic [OW-1:0] audio_out;
   logic          audio_valid_out;
   logic          underrun_out;
   logic          overflow_out;

   window_bufferizer #(
      .SAMPLE_W(SW), .OUT_W(OW), .TAU_W(TW), .WINDOW_SIZE(WS),
      .BURST_PERIOD(BP), .OUT_DEPTH(OD), .PLAY_PERIOD(PP)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in),
      .sample_in(sample_in), .sample_valid_in(sample_valid_in),
      .tau_in(tau_in), .tau_valid_in(tau_valid_in),
      .tau_out(tau_out), .tau_valid_out(tau_valid_out),
      .burst_sample_out(burst_sample_out), .burst_addr_out(burst_addr_out),
      .burst_valid_out(burst_valid_out), .burst_last_out(burst_last_out),
      .proc_sample_in(proc_sample_in), .proc_valid_in(proc_valid_in),
      .proc_done_in(proc_done_in),
      .audio_out(audio_out), .audio_valid_out(audio_valid_out),
      .underrun_out(underrun_out), .overflow_out(overflow_out)
   );

   always #5 clk_in = ~clk_in;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int stray_last = 0;
   int done_cyc = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   // Observed events, sampled 2 time units after each rising edge
   logic [TW-1:0] tau_v_q[$];
   int            tau_c_q[$];
   logic [SW-1:0] bs_q[$];
   logic [AW-1:0] ba_q[$];
   logic          bl_q[$];
   int            bc_q[$];
   logic [OW-1:0] av_q[$];
   logic          au_q[$];
   int            ac_q[$];

   always begin
      @(posedge clk_in);
      #2;
      if (tau_valid_out) begin
         tau_v_q.push_back(tau_out);
         tau_c_q.push_back(cyc);
      end
      if (burst_valid_out) begin
         bs_q.push_back(burst_sample_out);
         ba_q.push_back(burst_addr_out);
         bl_q.push_back(burst_last_out);
         bc_q.push_back(cyc);
      end
      if (burst_last_out && !burst_valid_out) stray_last++;
      if (audio_valid_out) begin
         av_q.push_back(audio_out);
         au_q.push_back(underrun_out);
         ac_q.push_back(cyc);
      end
   end

   // Reference model: window fill list, last completed window, output FIFO contents
   logic [SW-1:0] m_fill[$];
   logic [SW-1:0] m_ready[$];
   logic [OW-1:0] m_fifo[$];
   logic [OW-1:0] m_last;
   bit            m_avail, m_ovf, m_und;

   task automatic clear_obs();
      tau_v_q.delete(); tau_c_q.delete();
      bs_q.delete(); ba_q.delete(); bl_q.delete(); bc_q.delete();
      av_q.delete(); au_q.delete(); ac_q.delete();
      stray_last = 0;
   endtask

   task automatic do_reset();
      rst_in = 1'b1;
      sample_valid_in = 1'b0; tau_valid_in = 1'b0;
      proc_valid_in = 1'b0; proc_done_in = 1'b0;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      clear_obs();
      m_fill.delete(); m_ready.delete(); m_fifo.delete();
      m_last = '0; m_avail = 0; m_ovf = 0; m_und = 0;
   endtask

   task automatic send_sample(input logic [SW-1:0] v);
      sample_in = v;
      sample_valid_in = 1'b1;
      m_fill.push_back(v);
      if (m_fill.size() == WS) begin
         if (m_avail) m_ovf = 1;
         m_ready = m_fill;
         m_avail = 1;
         m_fill.delete();
      end
      @(negedge clk_in);
      sample_valid_in = 1'b0;
   endtask

   task automatic send_tau(input logic [TW-1:0] t);
      tau_in = t;
      tau_valid_in = 1'b1;
      @(negedge clk_in);
      tau_valid_in = 1'b0;
   endtask

   task automatic push_proc(input logic [OW-1:0] v);
      proc_sample_in = v;
      proc_valid_in = 1'b1;
      if (m_fifo.size() < OD) m_fifo.push_back(v);
      else m_ovf = 1;
      @(negedge clk_in);
      proc_valid_in = 1'b0;
   endtask

   task automatic pulse_done();
      proc_done_in = 1'b1;
      done_cyc = cyc;
      @(negedge clk_in);
      proc_done_in = 1'b0;
   endtask

   task automatic model_play(output logic [OW-1:0] v, output logic u);
      if (m_fifo.size() > 0) begin
         v = m_fifo.pop_front();
         m_last = v;
      end else begin
         m_und = 1;
`ifdef WINDOW_BUFFERIZER_HOLD_EN
         v = m_last;
`else
         v = '0;
`endif
      end
      u = m_und;
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int t = 0; t < budget && bs_q.size() < n; t++) @(negedge clk_in);
   endtask

   task automatic wait_audio(input int n, input int budget);
      for (int t = 0; t < budget && av_q.size() < n; t++) @(negedge clk_in);
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({tau_valid_out, burst_valid_out, burst_last_out, audio_valid_out, underrun_out, overflow_out} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b want 000000",
            {tau_valid_out, burst_valid_out, burst_last_out, audio_valid_out, underrun_out, overflow_out});
      end
      vectors++;
      if (tau_out !== '0) begin miscompares++; $display("FAIL reset_tau: got %0h want 0", tau_out); end
      vectors++;
      if (burst_sample_out !== '0) begin miscompares++; $display("FAIL reset_sample: got %0h want 0", burst_sample_out); end
      vectors++;
      if (burst_addr_out !== '0) begin miscompares++; $display("FAIL reset_addr: got %0h want 0", burst_addr_out); end
      vectors++;
      if (audio_out !== '0) begin miscompares++; $display("FAIL reset_audio: got %0h want 0", audio_out); end
   endtask

   task automatic test_capture_burst();
      logic [SW-1:0] exp[$];
      do_reset();
      for (int i = 1; i <= WS; i++) send_sample(SW'(i));
      send_tau(TW'(5));
      exp = m_ready; m_avail = 0;
      wait_beats(WS, 60);
      repeat (10) @(negedge clk_in);
      vectors++;
      if (tau_v_q.size() !== 1) begin miscompares++; $display("FAIL cap_tau_count: got %0d want 1", tau_v_q.size()); end
      vectors++;
      if (bs_q.size() !== WS) begin miscompares++; $display("FAIL cap_beat_count: got %0d want %0d", bs_q.size(), WS); end
      if (tau_v_q.size() == 1 && bs_q.size() == WS) begin
         vectors++;
         if (tau_v_q[0] !== TW'(5)) begin miscompares++; $display("FAIL cap_tau: got %0d want 5", tau_v_q[0]); end
         vectors++;
         if (bc_q[0] - tau_c_q[0] !== BP + 1) begin
            miscompares++; $display("FAIL cap_latency: got %0d want %0d", bc_q[0] - tau_c_q[0], BP + 1);
         end
         for (int i = 0; i < WS; i++) begin
            vectors++;
            if ({bs_q[i], ba_q[i], bl_q[i]} !== {exp[i], AW'(i), 1'(i == WS - 1)}) begin
               miscompares++;
               $display("FAIL cap_beat%0d: got s=%0h a=%0d l=%b want s=%0h a=%0d l=%b",
                  i, bs_q[i], ba_q[i], bl_q[i], exp[i], i, i == WS - 1);
            end
            if (i > 0) begin
               vectors++;
               if (bc_q[i] - bc_q[i-1] !== BP) begin
                  miscompares++; $display("FAIL cap_spacing%0d: got %0d want %0d", i, bc_q[i] - bc_q[i-1], BP);
               end
            end
         end
      end
      vectors++;
      if (stray_last !== 0) begin miscompares++; $display("FAIL cap_stray_last: got %0d want 0", stray_last); end
   endtask

   task automatic test_tau_first();
      logic [SW-1:0] exp1[$];
      logic [SW-1:0] exp2[$];
      do_reset();
      for (int i = 0; i < 4; i++) send_sample(SW'($urandom));
      send_tau(TW'(3));
      repeat (10) @(negedge clk_in);
      vectors++;
      if (tau_v_q.size() + bs_q.size() !== 0) begin
         miscompares++; $display("FAIL early_burst: got %0d events want 0", tau_v_q.size() + bs_q.size());
      end
      for (int i = 0; i < 4; i++) send_sample(SW'($urandom));
      exp1 = m_ready; m_avail = 0;
      for (int t = 0; t < 40 && tau_v_q.size() == 0; t++) @(negedge clk_in);
      send_tau(TW'(4));
      wait_beats(WS, 60);
      repeat (6) @(negedge clk_in);
      vectors++;
      if (tau_v_q.size() !== 1) begin miscompares++; $display("FAIL tf_tau_count1: got %0d want 1", tau_v_q.size()); end
      if (tau_v_q.size() >= 1) begin
         vectors++;
         if (tau_v_q[0] !== TW'(3)) begin miscompares++; $display("FAIL tf_tau1: got %0d want 3", tau_v_q[0]); end
      end
      pulse_done();
      repeat (6) @(negedge clk_in);
      vectors++;
      if (tau_v_q.size() !== 1) begin miscompares++; $display("FAIL tf_no_window: got %0d taus want 1", tau_v_q.size()); end
      for (int i = 0; i < WS; i++) send_sample(SW'($urandom));
      exp2 = m_ready; m_avail = 0;
      wait_beats(2 * WS, 80);
      vectors++;
      if (bs_q.size() !== 2 * WS || tau_v_q.size() !== 2) begin
         miscompares++; $display("FAIL tf_counts: got %0d beats %0d taus want %0d beats 2 taus", bs_q.size(), tau_v_q.size(), 2 * WS);
      end else begin
         vectors++;
         if (tau_v_q[1] !== TW'(4)) begin miscompares++; $display("FAIL tf_tau2: got %0d want 4", tau_v_q[1]); end
         for (int i = 0; i < WS; i++) begin
            vectors++;
            if ({bs_q[i], ba_q[i], bs_q[WS+i], ba_q[WS+i]} !== {exp1[i], AW'(i), exp2[i], AW'(i)}) begin
               miscompares++;
               $display("FAIL tf_beat%0d: got %0h/%0d %0h/%0d want %0h/%0d %0h/%0d",
                  i, bs_q[i], ba_q[i], bs_q[WS+i], ba_q[WS+i], exp1[i], i, exp2[i], i);
            end
         end
      end
      vectors++;
      if (overflow_out !== m_ovf) begin miscompares++; $display("FAIL tf_overflow: got %b want %b", overflow_out, m_ovf); end
   endtask

   task automatic test_window_overrun();
      logic [SW-1:0] all[$];
      logic [TW-1:0] t;
      do_reset();
      for (int i = 0; i < 2 * WS; i++) begin
         all.push_back(SW'($urandom));
         send_sample(all[i]);
      end
      vectors++;
      if (overflow_out !== m_ovf) begin miscompares++; $display("FAIL ovr_flag: got %b want %b", overflow_out, m_ovf); end
      repeat (4) @(negedge clk_in);
      vectors++;
      if (tau_v_q.size() !== 0) begin miscompares++; $display("FAIL ovr_no_tau: got %0d want 0", tau_v_q.size()); end
      t = TW'($urandom);
      send_tau(t);
      m_avail = 0;
      wait_beats(WS, 60);
      vectors++;
      if (bs_q.size() !== WS || tau_v_q.size() !== 1) begin
         miscompares++; $display("FAIL ovr_counts: got %0d beats %0d taus want %0d beats 1 tau", bs_q.size(), tau_v_q.size(), WS);
      end else begin
         vectors++;
         if (tau_v_q[0] !== t) begin miscompares++; $display("FAIL ovr_tau: got %0d want %0d", tau_v_q[0], t); end
         for (int i = 0; i < WS; i++) begin
            vectors++;
            if ({bs_q[i], ba_q[i]} !== {all[WS+i], AW'(i)}) begin
               miscompares++; $display("FAIL ovr_beat%0d: got %0h/%0d want %0h/%0d", i, bs_q[i], ba_q[i], all[WS+i], i);
            end
         end
      end
   endtask

   task automatic test_playback();
      logic [OW-1:0] ev;
      logic          eu;
      do_reset();
      push_proc(32'hA);
      push_proc(32'hB);
      pulse_done();
      wait_audio(3, 40);
      vectors++;
      if (av_q.size() !== 3) begin
         miscompares++; $display("FAIL play_count: got %0d want 3", av_q.size());
      end else begin
         vectors++;
         if (ac_q[0] - done_cyc !== PP + 1) begin
            miscompares++; $display("FAIL play_latency: got %0d want %0d", ac_q[0] - done_cyc, PP + 1);
         end
         for (int i = 0; i < 3; i++) begin
            model_play(ev, eu);
            vectors++;
            if ({av_q[i], au_q[i]} !== {ev, eu}) begin
               miscompares++; $display("FAIL play%0d: got %0h u=%b want %0h u=%b", i, av_q[i], au_q[i], ev, eu);
            end
            if (i > 0) begin
               vectors++;
               if (ac_q[i] - ac_q[i-1] !== PP) begin
                  miscompares++; $display("FAIL play_period%0d: got %0d want %0d", i, ac_q[i] - ac_q[i-1], PP);
               end
            end
         end
      end
      vectors++;
      if (overflow_out !== 1'b0) begin miscompares++; $display("FAIL play_overflow: got %b want 0", overflow_out); end
   endtask

   task automatic test_fifo_full();
      logic [OW-1:0] ev;
      logic          eu;
      do_reset();
      for (int i = 0; i <= OD; i++) push_proc($urandom);
      vectors++;
      if (overflow_out !== m_ovf) begin miscompares++; $display("FAIL full_overflow: got %b want %b", overflow_out, m_ovf); end
      pulse_done();
      wait_audio(OD + 1, (OD + 1) * PP + 20);
      vectors++;
      if (av_q.size() !== OD + 1) begin
         miscompares++; $display("FAIL full_count: got %0d want %0d", av_q.size(), OD + 1);
      end else begin
         for (int i = 0; i <= OD; i++) begin
            model_play(ev, eu);
            vectors++;
            if ({av_q[i], au_q[i]} !== {ev, eu}) begin
               miscompares++; $display("FAIL full_play%0d: got %0h u=%b want %0h u=%b", i, av_q[i], au_q[i], ev, eu);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [TW+SW+AW+OW+6-1:0] all_o;
      logic [TW-1:0]            t;
      logic [SW-1:0]            exp[$];
      do_reset();
      for (int i = 0; i < WS; i++) send_sample(SW'($urandom));
      send_tau(TW'($urandom));
      wait_beats(3, 40);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      all_o = {tau_out, tau_valid_out, burst_sample_out, burst_addr_out, burst_valid_out,
               burst_last_out, audio_out, audio_valid_out, underrun_out, overflow_out};
      vectors++;
      if (all_o !== '0) begin miscompares++; $display("FAIL mid_reset_outputs: got %0h want 0", all_o); end
      repeat (30) @(negedge clk_in);
      vectors++;
      if (bs_q.size() !== 3) begin miscompares++; $display("FAIL mid_reset_beats: got %0d want 3", bs_q.size()); end
      clear_obs();
      m_fill.delete(); m_ready.delete(); m_avail = 0; m_ovf = 0;
      for (int i = 0; i < WS; i++) send_sample(SW'($urandom));
      t = TW'($urandom);
      send_tau(t);
      exp = m_ready; m_avail = 0;
      wait_beats(WS, 60);
      vectors++;
      if (bs_q.size() !== WS || tau_v_q.size() !== 1) begin
         miscompares++; $display("FAIL restart_counts: got %0d beats %0d taus want %0d beats 1 tau", bs_q.size(), tau_v_q.size(), WS);
      end else begin
         vectors++;
         if (tau_v_q[0] !== t) begin miscompares++; $display("FAIL restart_tau: got %0d want %0d", tau_v_q[0], t); end
         for (int i = 0; i < WS; i++) begin
            vectors++;
            if ({bs_q[i], ba_q[i]} !== {exp[i], AW'(i)}) begin
               miscompares++; $display("FAIL restart_beat%0d: got %0h/%0d want %0h/%0d", i, bs_q[i], ba_q[i], exp[i], i);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [SW-1:0] exp[$];
      logic [TW-1:0] t;
      do_reset();
      for (int r = 0; r < 3; r++) begin
         clear_obs();
         for (int i = 0; i < WS; i++) begin
            send_sample(SW'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
         end
         t = TW'($urandom);
         send_tau(t);
         exp = m_ready; m_avail = 0;
         wait_beats(WS, 60);
         vectors++;
         if (bs_q.size() !== WS || tau_v_q.size() !== 1) begin
            miscompares++; $display("FAIL b2b%0d_counts: got %0d beats %0d taus", r, bs_q.size(), tau_v_q.size());
         end else begin
            vectors++;
            if (tau_v_q[0] !== t) begin miscompares++; $display("FAIL b2b%0d_tau: got %0d want %0d", r, tau_v_q[0], t); end
            for (int i = 0; i < WS; i++) begin
               vectors++;
               if ({bs_q[i], ba_q[i], bl_q[i]} !== {exp[i], AW'(i), 1'(i == WS - 1)}) begin
                  miscompares++; $display("FAIL b2b%0d_beat%0d: got %0h/%0d/%b want %0h/%0d", r, i, bs_q[i], ba_q[i], bl_q[i], exp[i], i);
               end
            end
         end
         repeat (2) @(negedge clk_in);
         pulse_done();
         repeat (2) @(negedge clk_in);
      end
      vectors++;
      if (overflow_out !== m_ovf) begin miscompares++; $display("FAIL b2b_overflow: got %b want %b", overflow_out, m_ovf); end
   endtask

   initial begin
      test_reset();
      test_capture_burst();
      test_tau_first();
      test_window_overrun();
      test_playback();
      test_fifo_full();
      test_reset_mid_burst();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
